inst_fetch_unit: RTL and testbench
==================================

// Module: inst_fetch_unit
// PURPOSE
// Instruction fetch stage; sits directly upstream of the decode stage (IDU) and supplies its 32-bit inst.
// Holds the PC, issues one word fetch at a time to instruction memory, and buffers the returned word.
// Presents {inst, pc} to decode over a valid/ready handshake.
// Accepts a redirect from execute and discards any fetch already in flight.
// PARAMETERS
// RESET_PC  64'h0000_0000_8000_0000  PC value loaded on reset
// PORTS
// clock               in   1   single clock, rising edge
// reset               in   1   synchronous, active-high
// io_imem_req_valid   out  1   fetch request valid
// io_imem_req_ready   in   1   memory accepts request this cycle
// io_imem_req_addr    out  64  fetch address (= pc, bits[1:0]=0)
// io_imem_resp_valid  in   1   response word valid
// io_imem_resp_data   in   32  instruction word
// io_imem_resp_err    in   1   access fault for this response
// io_out_valid        out  1   {inst,pc,err} valid to decode
// io_out_ready        in   1   decode consumes this cycle
// io_out_inst         out  32  fetched instruction
// io_out_pc           out  64  PC of io_out_inst
// io_out_err          out  1   fetch fault flag for io_out_inst
// io_redirect_valid   in   1   redirect request (branch/jump/trap)
// io_redirect_pc      in   64  new PC; bits[1:0] ignored (forced 0)
// BEHAVIOUR
// - One clock. Reset is synchronous and active-high.
// - Reset values: pc=RESET_PC, state=REQ, kill=0, out_valid=0, out_inst=0, out_pc=0, out_err=0.
// - io_imem_req_valid is 0 while reset=1.
// - States:
//   - REQ: req_valid = !out_valid | out_ready; req_addr = pc. On req_valid & req_ready -> WAIT.
//   - WAIT: wait for resp_valid. Memory never returns a response in the same cycle it accepts the request.
//     - resp_valid & !kill: out_buf <= {data, pc, err}, out_valid <= 1, pc <= pc+4 -> REQ.
//     - resp_valid & kill: drop the word, kill <= 0 -> REQ.
// - At most one fetch is outstanding. Best-case latency: request accepted in cycle N, response in N+1, out_valid in N+2.
// - Output buffer:
//   - out_valid & out_ready clears out_valid unless a new word is captured in the same cycle.
//   - While out_valid & !out_ready, the buffer holds stable. The combinational path out_ready -> req_valid is allowed.
// - pc+4 wraps modulo 2^64.
// - Redirect has highest priority, every cycle:
//   - pc <= {redirect_pc[63:2], 2'b00}; out_valid <= 0.
//   - In REQ without a handshake this cycle: stay in REQ.
//   - In REQ with a handshake this cycle (request left with the old address): -> WAIT, kill <= 1.
//   - In WAIT without resp_valid: kill <= 1, stay in WAIT.
//   - In WAIT with resp_valid in the same cycle: drop the response, kill stays 0, -> REQ.
//   - In WAIT with kill already set: kill stays 1.
// - A faulting response (resp_err=1) is delivered like a normal word with out_err=1. Fetching continues at pc+4; execute must redirect on the fault.
// - Reset asserted mid-fetch returns to the reset values. A response arriving after reset in REQ state is ignored.
// TESTING
// - Reset released -> req_valid=1, req_addr=0x80000000, out_valid=0.
// - req_ready=1; resp 0x00100093 one cycle later; out_ready=1 -> out_inst=0x00100093, out_pc=0x80000000, out_valid for 1 cycle; next req_addr=0x80000004.
// - out_ready held 0 after first word -> req_valid=0 and out_* stable for 10 cycles; out_ready=1 -> next req 0x80000004 issued that cycle.
// - Redirect to 0x80000103 while in WAIT -> next response dropped, out_valid stays 0, following req_addr=0x80000100.
// - Redirect (0x80000200) with resp_valid in the same cycle -> word dropped, req_addr=0x80000200 next cycle, kill=0.
// - RESET_PC=64'hFFFF_FFFF_FFFF_FFFC, one fetch -> out_pc=0xFFFF_FFFF_FFFF_FFFC, next req_addr=0.

Source files
------------

// File: rtl/inst_fetch_unit.sv
// inst_fetch_unit: single-outstanding instruction fetch with one-entry output buffer and redirect/kill.
module inst_fetch_unit #(
  parameter logic [63:0] RESET_PC = 64'h0000_0000_8000_0000
) (
  input  logic        clock,
  input  logic        reset,
  output logic        io_imem_req_valid,
  input  logic        io_imem_req_ready,
  output logic [63:0] io_imem_req_addr,
  input  logic        io_imem_resp_valid,
  input  logic [31:0] io_imem_resp_data,
  input  logic        io_imem_resp_err,
  output logic        io_out_valid,
  input  logic        io_out_ready,
  output logic [31:0] io_out_inst,
  output logic [63:0] io_out_pc,
  output logic        io_out_err,
  input  logic        io_redirect_valid,
  input  logic [63:0] io_redirect_pc
);
  typedef enum logic {S_REQ, S_WAIT} state_t;
  state_t      state_q, state_d;
  logic [63:0] pc_q, pc_d, out_pc_q, out_pc_d;
  logic [31:0] out_inst_q, out_inst_d;
  logic        kill_q, kill_d, out_valid_q, out_valid_d, out_err_q, out_err_d;
  logic        hs, resp_in, capture;
  assign io_imem_req_addr = pc_q & ~64'd3;
  assign io_out_valid     = out_valid_q;
  assign io_out_inst      = out_inst_q;
  assign io_out_pc        = out_pc_q;
  assign io_out_err       = out_err_q;
  always_comb begin
    io_imem_req_valid = !reset && state_q == S_REQ && (!out_valid_q || io_out_ready);
    hs          = io_imem_req_valid && io_imem_req_ready;
    resp_in     = state_q == S_WAIT && io_imem_resp_valid;
    capture     = resp_in && !kill_q && !io_redirect_valid;
    state_d     = hs ? S_WAIT : resp_in ? S_REQ : state_q;
    kill_d      = hs ? io_redirect_valid : resp_in ? 1'b0 : (kill_q || (state_q == S_WAIT && io_redirect_valid));
    out_valid_d = !io_redirect_valid && (capture || (out_valid_q && !io_out_ready));
    out_inst_d  = capture ? io_imem_resp_data : out_inst_q;
    out_pc_d    = capture ? pc_q : out_pc_q;
    out_err_d   = capture ? io_imem_resp_err : out_err_q;
    // redirect overrides the sequential increment
    pc_d        = io_redirect_valid ? (io_redirect_pc & ~64'd3) : capture ? pc_q + 64'd4 : pc_q;
  end
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q     <= S_REQ;
      pc_q        <= RESET_PC;
      kill_q      <= 1'b0;
      out_valid_q <= 1'b0;
      out_inst_q  <= '0;
      out_pc_q    <= '0;
      out_err_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      pc_q        <= pc_d;
      kill_q      <= kill_d;
      out_valid_q <= out_valid_d;
      out_inst_q  <= out_inst_d;
      out_pc_q    <= out_pc_d;
      out_err_q   <= out_err_d;
    end
  end
endmodule

// File: tb/tb_inst_fetch_unit.sv
// tb_inst_fetch_unit: directed pins plus randomized run against a transaction-level fetch model.
module tb_inst_fetch_unit;
  logic        clock, reset;
  logic        req_valid, req_ready, resp_valid, resp_err, out_valid, out_ready, out_err, redir;
  logic [63:0] req_addr, out_pc, redir_pc;
  logic [31:0] resp_data, out_inst;
  logic        b_reset, b_req_valid, b_req_ready, b_resp_valid, b_resp_err, b_out_valid, b_out_ready, b_out_err, b_redir;
  logic [63:0] b_req_addr, b_out_pc, b_redir_pc;
  logic [31:0] b_resp_data, b_out_inst;
  int tests = 0, fails = 0;
  bit          m_busy, m_stale, m_ov, m_err;
  logic [63:0] m_pc, m_opc;
  logic [31:0] m_inst;
  bit          pending;
  int          delay, rst_left;
  logic [63:0] mem_addr;

  inst_fetch_unit dut (
    .clock(clock), .reset(reset),
    .io_imem_req_valid(req_valid), .io_imem_req_ready(req_ready), .io_imem_req_addr(req_addr),
    .io_imem_resp_valid(resp_valid), .io_imem_resp_data(resp_data), .io_imem_resp_err(resp_err),
    .io_out_valid(out_valid), .io_out_ready(out_ready), .io_out_inst(out_inst), .io_out_pc(out_pc),
    .io_out_err(out_err), .io_redirect_valid(redir), .io_redirect_pc(redir_pc));

  inst_fetch_unit #(.RESET_PC(64'hFFFF_FFFF_FFFF_FFFC)) dut_wrap (
    .clock(clock), .reset(b_reset),
    .io_imem_req_valid(b_req_valid), .io_imem_req_ready(b_req_ready), .io_imem_req_addr(b_req_addr),
    .io_imem_resp_valid(b_resp_valid), .io_imem_resp_data(b_resp_data), .io_imem_resp_err(b_resp_err),
    .io_out_valid(b_out_valid), .io_out_ready(b_out_ready), .io_out_inst(b_out_inst), .io_out_pc(b_out_pc),
    .io_out_err(b_out_err), .io_redirect_valid(b_redir), .io_redirect_pc(b_redir_pc));

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic chk(input string n, input logic [63:0] got, input logic [63:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h at %0t", n, got, exp, $time);
    end
  endtask

  // Compare the DUT against the model, then advance the model by one clock using the applied inputs.
  task automatic step();
    bit rv, got;
    #1;
    rv = !reset && !m_busy && (!m_ov || out_ready);
    chk("req_valid", req_valid, rv);
    chk("req_addr", req_addr, m_pc);
    chk("out_valid", out_valid, m_ov);
    chk("out_inst", out_inst, m_inst);
    chk("out_pc", out_pc, m_opc);
    chk("out_err", out_err, m_err);
    if (reset) begin
      m_busy = 0; m_stale = 0; m_ov = 0; m_err = 0;
      m_pc = 64'h8000_0000; m_opc = 0; m_inst = 0;
    end else begin
      got = m_busy && resp_valid;
      if (m_ov && out_ready) m_ov = 0;
      if (got) begin
        if (!m_stale && !redir) begin
          m_inst = resp_data; m_opc = m_pc; m_err = resp_err; m_ov = 1; m_pc = m_pc + 64'd4;
        end
        m_busy = 0; m_stale = 0;
      end else if (m_busy) m_stale = m_stale || redir;
      else if (rv && req_ready) begin
        m_busy = 1; m_stale = redir;
      end
      if (redir) begin
        m_pc = redir_pc & ~64'd3; m_ov = 0;
      end
    end
    @(negedge clock);
  endtask

  initial begin
    reset = 1; req_ready = 0; resp_valid = 0; resp_data = 0; resp_err = 0; out_ready = 0; redir = 0; redir_pc = 0;
    b_reset = 1; b_req_ready = 0; b_resp_valid = 0; b_resp_data = 0; b_resp_err = 0; b_out_ready = 0; b_redir = 0; b_redir_pc = 0;
    m_busy = 0; m_stale = 0; m_ov = 0; m_err = 0; m_pc = 64'h8000_0000; m_opc = 0; m_inst = 0;
    pending = 0; delay = 0; rst_left = 0; mem_addr = 0;
    @(negedge clock);
    step();
    reset = 0; req_ready = 1; out_ready = 1;
    #1 chk("rst_req_valid", req_valid, 1); chk("rst_addr", req_addr, 64'h8000_0000); chk("rst_out_valid", out_valid, 0);
    step();
    req_ready = 0; resp_valid = 1; resp_data = 32'h0010_0093;
    #1 chk("wait_no_req", req_valid, 0);
    step();
    resp_valid = 0;
    #1 chk("w1_valid", out_valid, 1); chk("w1_inst", out_inst, 32'h0010_0093);
    chk("w1_pc", out_pc, 64'h8000_0000); chk("w1_next_addr", req_addr, 64'h8000_0004);
    step();
    #1 chk("w1_one_cycle", out_valid, 0);
    req_ready = 1;
    step();
    req_ready = 0; resp_valid = 1; resp_data = 32'h0020_0113; out_ready = 0;
    step();
    resp_valid = 0;
    for (int i = 0; i < 10; i++) begin
      #1 chk("stall_req", req_valid, 0); chk("stall_inst", out_inst, 32'h0020_0113); chk("stall_valid", out_valid, 1);
      step();
    end
    out_ready = 1; req_ready = 1;
    #1 chk("unstall_req", req_valid, 1); chk("unstall_addr", req_addr, 64'h8000_0008);
    step();
    req_ready = 0; redir = 1; redir_pc = 64'h8000_0103;
    step();
    redir = 0; resp_valid = 1; resp_data = 32'hDEAD_BEEF;
    step();
    resp_valid = 0;
    #1 chk("kill_drop", out_valid, 0); chk("kill_req", req_valid, 1); chk("kill_addr", req_addr, 64'h8000_0100);
    req_ready = 1;
    step();
    req_ready = 0; resp_valid = 1; resp_data = 32'h1234_5678; redir = 1; redir_pc = 64'h8000_0200;
    step();
    resp_valid = 0; redir = 0;
    #1 chk("redir_resp_drop", out_valid, 0); chk("redir_resp_addr", req_addr, 64'h8000_0200);
    req_ready = 1;
    step();
    req_ready = 0; resp_valid = 1; resp_data = 32'h0BAD_C0DE; resp_err = 1;
    step();
    resp_valid = 0; resp_err = 0;
    #1 chk("err_valid", out_valid, 1); chk("err_pc", out_pc, 64'h8000_0200);
    chk("err_inst", out_inst, 32'h0BAD_C0DE); chk("err_flag", out_err, 1);
    step();
    for (int c = 0; c < 4000; c++) begin
      if (rst_left > 0) begin reset = 1; rst_left--; end
      else if ($urandom_range(0, 299) == 0) begin reset = 1; rst_left = $urandom_range(0, 2); end
      else reset = 0;
      resp_valid = pending && delay == 0;
      resp_data  = resp_valid ? (mem_addr[31:0] ^ 32'h5A5A_1234) : $urandom;
      resp_err   = resp_valid ? (mem_addr[6:2] == 5'd7) : 1'($urandom_range(0, 1));
      req_ready  = !pending && $urandom_range(0, 2) != 0;
      out_ready  = $urandom_range(0, 3) != 0;
      redir      = $urandom_range(0, 15) == 0;
      redir_pc   = ($urandom_range(0, 3) == 0) ? {32'hFFFF_FFFF, 32'hFFFF_FFF0 | $urandom_range(0, 15)} : {$urandom, $urandom};
      #1;
      if (resp_valid) pending = 0;
      else if (pending) delay--;
      if (req_valid && req_ready) begin
        pending = 1; mem_addr = req_addr; delay = $urandom_range(0, 2);
      end
      step();
    end
    reset = 1; redir = 0; resp_valid = 0; req_ready = 0;
    step();
    b_reset = 0; b_req_ready = 1; b_out_ready = 1;
    #1 chk("wrap_addr", b_req_addr, 64'hFFFF_FFFF_FFFF_FFFC); chk("wrap_req", b_req_valid, 1);
    step();
    b_req_ready = 0; b_resp_valid = 1; b_resp_data = 32'h0000_0013;
    step();
    b_resp_valid = 0;
    #1 chk("wrap_valid", b_out_valid, 1); chk("wrap_pc", b_out_pc, 64'hFFFF_FFFF_FFFF_FFFC);
    chk("wrap_inst", b_out_inst, 32'h0000_0013); chk("wrap_next", b_req_addr, 64'h0);
    step();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
